uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the fabric-side serial links. It supports 5-9 data bits, runtime-selectable parity and 1 or 2 stop bits. It reports parity, framing and break errors per character, and buffers received characters with their status flags in a show-ahead FIFO. Consumers read the FIFO through a valid/ready handshake.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BIT_RATE, 9600, line bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE, must be >= 8
PAYLOAD_BITS, 8, data bits per character, legal range 5..9
STOP_BITS, 1, stop bits checked, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries, power of two >= 2

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
uart_rxd  in  1  serial input, idle high
uart_rx_en  in  1  receive enable; low blocks new start-bit detection, a frame in progress completes
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; latched at start detection
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head when m_valid & m_ready
m_data  out  PAYLOAD_BITS  head character, LSB = first data bit received
m_perr  out  1  head parity error
m_ferr  out  1  head framing error (a stop bit sampled low)
m_break  out  1  head is a break condition
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
overflow  out  1  sticky: a completed character was dropped because the FIFO was full
status_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, resetn low): all state is cleared. FIFO empty, m_valid=0, fifo_count=0, overflow=0, m_data/m_perr/m_ferr/m_break=0. Synchroniser flops reset to 1. FSM goes to IDLE. A reset mid-frame discards the partial character.
- uart_rxd passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Bit sampling happens at cycle counter == CYCLES_PER_BIT/2 within each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE -> START: on rxd==0 with uart_rx_en=1. Cycle counter cleared; parity_mode latched.
- START: if the mid-bit sample is 1, false start; return to IDLE with no FIFO write. Otherwise go to DATA at counter == CYCLES_PER_BIT-1.
- DATA: shift in PAYLOAD_BITS bits, LSB first. Then go to PARITY if latched mode is 01 or 10, else to STOP.
- PARITY: sample the parity bit. Even: error if XOR(data, parity) = 1. Odd: error if XOR(data, parity) = 0.
- STOP: sample each of the STOP_BITS stop bits. Any low sample sets ferr. The frame completes at the mid-bit sample of the last stop bit, without waiting for the bit end.
- Break: on completion, if data==0, ferr=1 and the parity bit (if present) is 0, then break=1 and the FSM enters BREAK. BREAK waits for rxd==1, then goes to IDLE. Otherwise the FSM goes directly to IDLE.
- FIFO write: on completion, write {break, ferr, perr, data} in one cycle. m_valid rises on the following clock edge, giving 1-cycle latency.
- FIFO full on completion: the character is dropped, overflow is set, and contents are unchanged. Exception: a pop in the same cycle frees space and the write is accepted.
- Simultaneous write and pop with FIFO empty: no bypass; the write becomes visible next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is in 0..FIFO_DEPTH.
- status_clr together with a new overflow event in the same cycle: overflow remains 1 (set wins).
- m_* outputs show the head entry; they are held stable while m_valid=1 and m_ready=0.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the majority of three samples at counters CYCLES_PER_BIT/2-1, /2 and /2+1. This applies to start, data, parity and stop bits.
- Undefined: a single sample at CYCLES_PER_BIT/2.
- The frame completion point is identical in both builds.

Test Plan:
All scenarios use CLK_HZ=1_000_000, BIT_RATE=100_000 (10 cycles/bit), PAYLOAD_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
1. Mode 00, send 0xA5 with 8N1 framing, m_ready=1 -> one beat m_data=0xA5, perr=ferr=break=0, m_valid one cycle after the stop mid-bit.
2. Mode 01, send 0x07 with parity bit 0 -> m_data=0x07, m_perr=1. Repeat with mode 10 and parity bit 0 -> m_perr=0.
3. Mode 00, send 0x3C with the stop bit held low, then line high -> m_data=0x3C, m_ferr=1, m_break=0. Then hold line low for 30 bit times -> one entry with data=0x00, ferr=1, break=1; no further entries until the line returns high.
4. m_ready=0, send 5 characters 0x01..0x05 -> fifo_count=4, overflow=1, entries 0x01..0x04. Pulse status_clr -> overflow=0. Drain -> 0x01..0x04 in order.
5. A 3-cycle low glitch on an idle line -> false start, no FIFO write. Assert resetn low mid-frame -> fifo_count=0 and m_valid=0 immediately; the next clean frame 0x5A is received correctly.
6. With UART_RX_MAJORITY_EN defined, force a 1-cycle inverted spike at the mid-bit of data bit 3 of 0x00 -> m_data=0x00. Without the macro -> m_data=0x08.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Generic show-ahead FIFO; head is visible as soon as an entry is written.
// Latency: a push shows at dout/count one cycle later, with no write-to-read bypass.
// Backpressure: a push when full is ignored unless a pop frees space in the same cycle.
module rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// UART receiver with status flags into a show-ahead FIFO; UART_RX_MAJORITY_EN selects 3-sample voting.
// Latency: character appears at m_valid one cycle after the last stop bit's mid-bit sample.
// Backpressure: m_valid/m_ready; a character completing into a full FIFO is dropped and flags overflow.
module uart_rx_fifo #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            uart_rxd,
    input  logic                            uart_rx_en,
    input  logic [1:0]                      parity_mode,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [PAYLOAD_BITS-1:0]         m_data,
    output logic                            m_perr,
    output logic                            m_ferr,
    output logic                            m_break,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    input  logic                            status_clr
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(PAYLOAD_BITS);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    typedef struct packed {
        logic                    brk;
        logic                    ferr;
        logic                    perr;
        logic [PAYLOAD_BITS-1:0] data;
    } entry_t;

    state_t                  state, state_nxt;
    logic                    rxd_s1, rxd_s2, bit_val;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bit_idx;
    logic                    stop_idx;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [1:0]              mode_q;
    logic                    par_bit, ferr_acc;
    logic                    mid, bit_end, par_en, par_odd, done, pop;
    logic                    fifo_full, fifo_empty;
    entry_t                  wr_entry, head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    logic smp_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)             smp_prev <= 1'b1;
        else if (cnt == HALF_M1) smp_prev <= rxd_s2;
    end

    // rxd_s1 already holds the value rxd_s2 takes next cycle, so the vote lands at the mid-bit count.
    assign bit_val = (smp_prev & rxd_s2) | (smp_prev & rxd_s1) | (rxd_s2 & rxd_s1);
`else
    assign bit_val = rxd_s2;
`endif

    assign mid     = (cnt == HALF);
    assign bit_end = (cnt == LAST);
    assign par_en  = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign par_odd = (mode_q == 2'b10);

    assign wr_entry.data = shreg;
    assign wr_entry.ferr = ferr_acc | ~bit_val;
    assign wr_entry.perr = par_en & (^shreg ^ par_bit ^ par_odd);
    assign wr_entry.brk  = (shreg == '0) & wr_entry.ferr & ~(par_en & par_bit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE:   if (!rxd_s2 && uart_rx_en) state_nxt = S_START;
            S_START: begin
                if (mid && bit_val) state_nxt = S_IDLE;
                else if (bit_end)   state_nxt = S_DATA;
            end
            S_DATA:   if (bit_end && bit_idx == BW'(PAYLOAD_BITS - 1))
                          state_nxt = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP: begin
                if (mid && stop_idx == 1'(STOP_BITS - 1)) begin
                    done      = 1'b1;
                    state_nxt = wr_entry.brk ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK:  if (rxd_s2) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            mode_q   <= 2'b00;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            cnt <= (state_nxt != state || bit_end) ? '0 : cnt + CW'(1);
            case (state)
                // Parity mode tracks the input while idle, so it is frozen at start detection.
                S_IDLE: begin
                    mode_q   <= parity_mode;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_bit  <= 1'b0;
                    ferr_acc <= 1'b0;
                end
                S_DATA: begin
                    if (mid)     shreg   <= {bit_val, shreg[PAYLOAD_BITS-1:1]};
                    if (bit_end) bit_idx <= bit_idx + BW'(1);
                end
                S_PARITY: if (mid) par_bit <= bit_val;
                S_STOP: begin
                    if (mid && !bit_val) ferr_acc <= 1'b1;
                    if (bit_end)         stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           overflow <= 1'b0;
        else if (done && fifo_full && !pop)    overflow <= 1'b1;
        else if (status_clr)                   overflow <= 1'b0;
    end

    rx_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (done),
        .din    (wr_entry),
        .pop    (pop),
        .dout   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? head.data : '0;
    assign m_perr  = m_valid & head.perr;
    assign m_ferr  = m_valid & head.ferr;
    assign m_break = m_valid & head.brk;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clocks per bit, 8 data bits, 1 stop bit, 4-entry FIFO.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       resetn, uart_rxd, uart_rx_en, m_ready, status_clr;
    logic [1:0] parity_mode;
    logic       m_valid, m_perr, m_ferr, m_break, overflow;
    logic [7:0] m_data;
    logic [2:0] fifo_count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ       (1_000_000),
        .BIT_RATE     (100_000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_rxd    (uart_rxd),
        .uart_rx_en  (uart_rx_en),
        .parity_mode (parity_mode),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_perr      (m_perr),
        .m_ferr      (m_ferr),
        .m_break     (m_break),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .status_clr  (status_clr)
    );

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            uart_rxd = bits[i];
            repeat (10) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1;
        m_ready = 1'b0; status_clr = 1'b0; parity_mode = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {m_perr, m_ferr, m_break}); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] bits;
        bits = frame8(8'hA5);
        parity_mode = 2'b00;
        m_ready = 1'b1;
        for (int c = 0; c < 110; c++) begin
            uart_rxd = (c < 100) ? bits[c/10] : 1'b1;
            @(negedge clk);
            if (c + 1 == 98) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", m_valid); end
            end
            if (c + 1 == 99) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", m_valid); end
                checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", m_data); end
                checks++; if ({m_perr, m_ferr, m_break} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {m_perr, m_ferr, m_break}); end
            end
            if (c + 1 == 100) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got %b want 0", m_valid); end
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_parity();
        parity_mode = 2'b01;
        send({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL even_valid got %b want 1", m_valid); end
        checks++; if (m_data !== 8'h07) begin errors++; $display("FAIL even_data got %h want 07", m_data); end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b100) begin errors++; $display("FAIL even_flags got %b want 100", {m_perr, m_ferr, m_break}); end
        pop_one();
        repeat (5) @(negedge clk);
        parity_mode = 2'b10;
        send({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        @(negedge clk);
        checks++; if (m_data !== 8'h07) begin errors++; $display("FAIL odd_data got %h want 07", m_data); end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b000) begin errors++; $display("FAIL odd_flags got %b want 000", {m_perr, m_ferr, m_break}); end
        pop_one();
        parity_mode = 2'b00;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_framing();
        send({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        repeat (20) @(negedge clk);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL ferr_count got %0d want 1", fifo_count); end
        checks++; if (m_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h want 3c", m_data); end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b010) begin errors++; $display("FAIL ferr_flags got %b want 010", {m_perr, m_ferr, m_break}); end
        pop_one();
        repeat (10) @(negedge clk);
        uart_rxd = 1'b0;
        repeat (300) @(negedge clk);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL break_count got %0d want 1", fifo_count); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL break_data got %h want 00", m_data); end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b011) begin errors++; $display("FAIL break_flags got %b want 011", {m_perr, m_ferr, m_break}); end
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL break_release_count got %0d want 1", fifo_count); end
        pop_one();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL break_drained got %0d want 0", fifo_count); end
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(frame8(8'(i)), 10);
        repeat (5) @(negedge clk);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 8'(i + 1)) begin
                errors++; $display("FAIL drain_%0d got valid %b data %h want valid 1 data %h", i, m_valid, m_data, 8'(i + 1));
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", m_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_glitch_reset();
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (fifo_count !== 3'd0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL glitch got count %0d valid %b want 0 0", fifo_count, m_valid);
        end
        send(frame8(8'h33), 10);
        @(negedge clk);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL pre_reset_count got %0d want 1", fifo_count); end
        uart_rxd = 1'b0;
        repeat (25) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", fifo_count); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", m_valid); end
        @(negedge clk);
        uart_rxd = 1'b1;
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        send(frame8(8'h5A), 10);
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
            errors++; $display("FAIL post_reset_data got valid %b data %h want valid 1 data 5a", m_valid, m_data);
        end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b000) begin errors++; $display("FAIL post_reset_flags got %b want 000", {m_perr, m_ferr, m_break}); end
        pop_one();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_spike();
        logic [15:0] bits;
        logic [7:0]  want;
`ifdef UART_RX_MAJORITY_EN
        want = 8'h00;
`else
        want = 8'h08;
`endif
        bits = frame8(8'h00);
        for (int c = 0; c < 100; c++) begin
            uart_rxd = bits[c/10] ^ (c == 46);
            @(negedge clk);
        end
        uart_rxd = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== want) begin
            errors++; $display("FAIL spike_data got valid %b data %h want valid 1 data %h", m_valid, m_data, want);
        end
        checks++; if ({m_perr, m_ferr, m_break} !== 3'b000) begin errors++; $display("FAIL spike_flags got %b want 000", {m_perr, m_ferr, m_break}); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_overflow();
        test_glitch_reset();
        test_spike();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
